apb_slave_mux_tmo: RTL and testbench

- Parametrised APB slave-select decoder and response multiplexer for the APB subsystem. It sits between the AHB-to-APB bridge and NUM_SLAVES peripherals.
- Decodes the upper PADDR slot field into one-hot PSEL_S and returns the selected slave's PRDATA/PREADY/PSLVERR to the bridge.
- Adds two behaviours: an error response for unmapped or disabled slots, and an access-phase watchdog. The watchdog aborts a hung slave transfer with PSLVERR and raises a sticky flag.

---
 rtl/apb_dec_pkg.sv | 19 +
 rtl/apb_dec_wdog_ctr.sv | 39 +++
 rtl/apb_slave_mux_tmo.sv | 169 ++++++++++++++++
 tb/tb_apb_slave_mux_tmo.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_dec_pkg.sv
// Shared types and constants for the APB slave-select decoder and its watchdog.
package apb_dec_pkg;

    localparam int APB_DW = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        ABORT
    } apb_dec_state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_UNMAPPED = 2'b01,
        ERR_TIMEOUT  = 2'b10
    } apb_dec_err_e;

endpackage

// File: rtl/apb_dec_wdog_ctr.sv
// Saturating access-phase wait counter; expire flags a stall cycle reaching the limit.
module apb_dec_wdog_ctr
    import apb_dec_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic expire
);

    // A limit of 0 disables the watchdog; keep a 1-bit counter so the logic stays legal.
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TMO_VAL = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (TIMEOUT_CYCLES != 0) && inc && (cnt_q == TMO_VAL);

endmodule

// File: rtl/apb_slave_mux_tmo.sv
// APB slave-select decoder and response mux with unmapped-slot errors and an access watchdog.
// Optional error log (ERR_ADDR/ERR_TYPE/ERR_CNT) is built when APB_DEC_ERR_LOG_EN is defined.
module apb_slave_mux_tmo
    import apb_dec_pkg::*;
#(
    parameter int                    NUM_SLAVES     = 6,
    parameter int                    ADDR_SEL_W     = 4,
    parameter logic [NUM_SLAVES-1:0] SLV_EN_MASK    = {NUM_SLAVES{1'b1}},
    parameter int                    TIMEOUT_CYCLES = 255
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    input  logic [ADDR_SEL_W-1:0]        PADDR,
    output logic [NUM_SLAVES-1:0]        PSEL_S,
    input  logic [NUM_SLAVES*APB_DW-1:0] PRDATA_S,
    input  logic [NUM_SLAVES-1:0]        PREADY_S,
    input  logic [NUM_SLAVES-1:0]        PSLVERR_S,
    output logic [APB_DW-1:0]            PRDATA,
    output logic                         PREADY,
    output logic                         PSLVERR,
    output logic                         TIMEOUT_IRQ,
`ifdef APB_DEC_ERR_LOG_EN
    output logic [ADDR_SEL_W-1:0]        ERR_ADDR,
    output logic [1:0]                   ERR_TYPE,
    output logic [7:0]                   ERR_CNT,
`endif
    input  logic                         TIMEOUT_CLR
);

    apb_dec_state_e state_q, state_d;
    logic irq_q, irq_d;

    logic [NUM_SLAVES-1:0] hit;
    logic [APB_DW-1:0]     slv_rdata;
    logic                  slv_rdy;
    logic                  slv_err;
    logic                  valid;
    logic                  acc;
    logic                  stall;
    logic                  expire;

    always_comb begin
        hit       = '0;
        slv_rdata = '0;
        slv_rdy   = 1'b0;
        slv_err   = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (PADDR == ADDR_SEL_W'(i)) begin
                hit[i]    = SLV_EN_MASK[i];
                slv_rdata = PRDATA_S[APB_DW*i +: APB_DW];
                slv_rdy   = PREADY_S[i];
                slv_err   = PSLVERR_S[i];
            end
        end
    end

    // Reset gates the combinational path too, so the bridge sees an idle bus while PRESET is high.
    assign valid  = |hit;
    assign acc    = PSEL & PENABLE & ~PRESET & (state_q != ABORT);
    assign stall  = acc & valid & ~slv_rdy;
    assign PSEL_S = (PSEL & ~PRESET & (state_q != ABORT)) ? hit : '0;

    apb_dec_wdog_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk   (PCLK),
        .rst   (PRESET),
        .inc   (stall),
        .clr   (~stall),
        .expire(expire)
    );

    always_comb begin
        PREADY  = 1'b1;
        PSLVERR = 1'b0;
        PRDATA  = '0;
        if (acc) begin
            if (!valid || expire) begin
                PSLVERR = 1'b1;
            end else begin
                PRDATA  = slv_rdata;
                PREADY  = slv_rdy;
                PSLVERR = slv_err;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (!PSEL) begin
            state_d = IDLE;
        end else if (expire) begin
            state_d = ABORT;
        end else begin
            case (state_q)
                IDLE:    if (!PENABLE) state_d = SETUP;
                SETUP:   if (PENABLE) state_d = PREADY ? IDLE : ACCESS;
                ACCESS:  if (PREADY || !PENABLE) state_d = IDLE;
                ABORT:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // A fresh expiry outranks a clear arriving in the same cycle.
    always_comb begin
        irq_d = irq_q;
        if (expire) begin
            irq_d = 1'b1;
        end else if (TIMEOUT_CLR) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= IDLE;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            irq_q   <= irq_d;
        end
    end

    assign TIMEOUT_IRQ = irq_q;

`ifdef APB_DEC_ERR_LOG_EN
    logic [ADDR_SEL_W-1:0] err_addr_q, err_addr_d;
    apb_dec_err_e          err_type_q, err_type_d;
    logic [7:0]            err_cnt_q, err_cnt_d;
    logic                  unmapped;

    assign unmapped = acc & ~valid;

    always_comb begin
        err_addr_d = err_addr_q;
        err_type_d = err_type_q;
        err_cnt_d  = err_cnt_q;
        if (unmapped || expire) begin
            err_addr_d = PADDR;
            err_type_d = expire ? ERR_TIMEOUT : ERR_UNMAPPED;
            err_cnt_d  = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
        end else if (TIMEOUT_CLR) begin
            err_addr_d = '0;
            err_type_d = ERR_NONE;
            err_cnt_d  = '0;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            err_addr_q <= '0;
            err_type_q <= ERR_NONE;
            err_cnt_q  <= '0;
        end else begin
            err_addr_q <= err_addr_d;
            err_type_q <= err_type_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign ERR_ADDR = err_addr_q;
    assign ERR_TYPE = err_type_q;
    assign ERR_CNT  = err_cnt_q;
`endif

endmodule

// File: tb/tb_apb_slave_mux_tmo.sv
// Directed self-checking bench for apb_slave_mux_tmo (6 slots, slot 3 disabled, 4-cycle watchdog).
module tb_apb_slave_mux_tmo;

    localparam int             NS   = 6;
    localparam int             AW   = 4;
    localparam int             TMO  = 4;
    localparam logic [NS-1:0]  MASK = 6'b110111;

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic              PSEL;
    logic              PENABLE;
    logic [AW-1:0]     PADDR;
    logic [NS-1:0]     PSEL_S;
    logic [NS*32-1:0]  PRDATA_S;
    logic [NS-1:0]     PREADY_S;
    logic [NS-1:0]     PSLVERR_S;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;
    logic              TIMEOUT_IRQ;
    logic              TIMEOUT_CLR;
`ifdef APB_DEC_ERR_LOG_EN
    logic [AW-1:0]     ERR_ADDR;
    logic [1:0]        ERR_TYPE;
    logic [7:0]        ERR_CNT;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 PCLK = ~PCLK;

    apb_slave_mux_tmo #(
        .NUM_SLAVES    (NS),
        .ADDR_SEL_W    (AW),
        .SLV_EN_MASK   (MASK),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PADDR      (PADDR),
        .PSEL_S     (PSEL_S),
        .PRDATA_S   (PRDATA_S),
        .PREADY_S   (PREADY_S),
        .PSLVERR_S  (PSLVERR_S),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR),
        .TIMEOUT_IRQ(TIMEOUT_IRQ),
`ifdef APB_DEC_ERR_LOG_EN
        .ERR_ADDR   (ERR_ADDR),
        .ERR_TYPE   (ERR_TYPE),
        .ERR_CNT    (ERR_CNT),
`endif
        .TIMEOUT_CLR(TIMEOUT_CLR)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic psel, input logic penable, input logic [AW-1:0] paddr);
        PSEL    = psel;
        PENABLE = penable;
        PADDR   = paddr;
    endtask

    task automatic nextCycle;
        @(posedge PCLK);
        #1;
    endtask

    task automatic checkResp(input string tag, input logic rdy, input logic err, input logic [31:0] data);
        checkOutput({tag, ".pready"}, 32'(PREADY), 32'(rdy));
        checkOutput({tag, ".pslverr"}, 32'(PSLVERR), 32'(err));
        checkOutput({tag, ".prdata"}, PRDATA, data);
    endtask

    // Wait-state access cycles on a stuck slot: bus must stay stalled and the slot selected.
    task automatic stallCycles(input int n, input logic [AW-1:0] slot, input string tag);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b1, slot);
            @(negedge PCLK);
            checkOutput($sformatf("%s.stall%0d.pready", tag, i + 1), 32'(PREADY), 32'd0);
            checkOutput($sformatf("%s.stall%0d.psel_s", tag, i + 1), 32'(PSEL_S), 32'd1 << slot);
            nextCycle();
        end
    endtask

    task automatic setupCycle(input logic [AW-1:0] slot);
        applyStimulus(1'b1, 1'b0, slot);
        nextCycle();
    endtask

    initial begin
        PRESET      = 1'b1;
        TIMEOUT_CLR = 1'b0;
        PREADY_S    = '1;
        PSLVERR_S   = '0;
        for (int i = 0; i < NS; i++) begin
            PRDATA_S[32*i +: 32] = 32'hA000_0000 + 32'(i);
        end

        // Reset with a live-looking access on the bus: outputs must still be idle.
        PREADY_S[2] = 1'b0;
        applyStimulus(1'b1, 1'b1, 4'd2);
        @(negedge PCLK);
        checkOutput("rst.psel_s", 32'(PSEL_S), 32'd0);
        checkResp("rst", 1'b1, 1'b0, 32'd0);
        checkOutput("rst.irq", 32'(TIMEOUT_IRQ), 32'd0);
        nextCycle();
        PRESET = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'd0);
        nextCycle();

        $display("[TB] slot 2 with three wait states");
        applyStimulus(1'b1, 1'b0, 4'd2);
        @(negedge PCLK);
        checkOutput("t1.setup.psel_s", 32'(PSEL_S), 32'h4);
        checkResp("t1.setup", 1'b1, 1'b0, 32'd0);
        nextCycle();
        stallCycles(3, 4'd2, "t1");
        PREADY_S[2] = 1'b1;
        applyStimulus(1'b1, 1'b1, 4'd2);
        @(negedge PCLK);
        checkOutput("t1.done.psel_s", 32'(PSEL_S), 32'h4);
        checkResp("t1.done", 1'b1, 1'b0, 32'hA000_0002);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 4'd0);
        @(negedge PCLK);
        checkOutput("t1.idle.psel_s", 32'(PSEL_S), 32'd0);
        nextCycle();

        $display("[TB] unmapped slot 7, disabled slot 3, slave error on slot 4");
        applyStimulus(1'b1, 1'b0, 4'd7);
        @(negedge PCLK);
        checkOutput("t2.s7.setup.psel_s", 32'(PSEL_S), 32'd0);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 4'd7);
        @(negedge PCLK);
        checkOutput("t2.s7.psel_s", 32'(PSEL_S), 32'd0);
        checkResp("t2.s7", 1'b1, 1'b1, 32'd0);
        nextCycle();
        setupCycle(4'd3);
        applyStimulus(1'b1, 1'b1, 4'd3);
        @(negedge PCLK);
        checkOutput("t2.s3.psel_s", 32'(PSEL_S), 32'd0);
        checkResp("t2.s3", 1'b1, 1'b1, 32'd0);
        nextCycle();
        PSLVERR_S[4] = 1'b1;
        setupCycle(4'd4);
        applyStimulus(1'b1, 1'b1, 4'd4);
        @(negedge PCLK);
        checkOutput("t2.s4.psel_s", 32'(PSEL_S), 32'h10);
        checkResp("t2.s4", 1'b1, 1'b1, 32'hA000_0004);
        nextCycle();
        PSLVERR_S[4] = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'd0);
        nextCycle();

        $display("[TB] slot 1 stuck: watchdog abort and clear");
        PREADY_S[1] = 1'b0;
        setupCycle(4'd1);
        stallCycles(TMO, 4'd1, "t3");
        applyStimulus(1'b1, 1'b1, 4'd1);
        @(negedge PCLK);
        checkResp("t3.expire", 1'b1, 1'b1, 32'd0);
        checkOutput("t3.expire.irq", 32'(TIMEOUT_IRQ), 32'd0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 4'd1);
        @(negedge PCLK);
        checkOutput("t3.abort.psel_s", 32'(PSEL_S), 32'd0);
        checkResp("t3.abort", 1'b1, 1'b0, 32'd0);
        checkOutput("t3.abort.irq", 32'(TIMEOUT_IRQ), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 4'd0);
        TIMEOUT_CLR = 1'b1;
        @(negedge PCLK);
        checkOutput("t3.clrcycle.irq", 32'(TIMEOUT_IRQ), 32'd1);
        nextCycle();
        TIMEOUT_CLR = 1'b0;
        @(negedge PCLK);
        checkOutput("t3.cleared.irq", 32'(TIMEOUT_IRQ), 32'd0);
        nextCycle();

        $display("[TB] slot 0 ready exactly on the expiry cycle");
        PREADY_S[0] = 1'b0;
        PRDATA_S[31:0] = 32'hDEAD_BEEF;
        setupCycle(4'd0);
        stallCycles(TMO, 4'd0, "t4");
        PREADY_S[0] = 1'b1;
        applyStimulus(1'b1, 1'b1, 4'd0);
        @(negedge PCLK);
        checkResp("t4.done", 1'b1, 1'b0, 32'hDEAD_BEEF);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 4'd0);
        @(negedge PCLK);
        checkOutput("t4.irq", 32'(TIMEOUT_IRQ), 32'd0);
        nextCycle();

        $display("[TB] expiry coincident with clear, then reset mid-access");
        setupCycle(4'd1);
        stallCycles(TMO, 4'd1, "t5a");
        applyStimulus(1'b1, 1'b1, 4'd1);
        TIMEOUT_CLR = 1'b1;
        @(negedge PCLK);
        checkResp("t5a.expire", 1'b1, 1'b1, 32'd0);
        nextCycle();
        TIMEOUT_CLR = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'd0);
        @(negedge PCLK);
        checkOutput("t5a.setwins.irq", 32'(TIMEOUT_IRQ), 32'd1);
        nextCycle();

        setupCycle(4'd1);
        stallCycles(3, 4'd1, "t5b");
        applyStimulus(1'b1, 1'b1, 4'd1);
        PRESET = 1'b1;
        @(negedge PCLK);
        checkResp("t5b.rst", 1'b1, 1'b0, 32'd0);
        checkOutput("t5b.rst.psel_s", 32'(PSEL_S), 32'd0);
        checkOutput("t5b.rst.irq", 32'(TIMEOUT_IRQ), 32'd0);
        nextCycle();
        PRESET = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'd0);
        nextCycle();

        setupCycle(4'd1);
        stallCycles(TMO, 4'd1, "t5c");
        applyStimulus(1'b1, 1'b1, 4'd1);
        @(negedge PCLK);
        checkResp("t5c.expire", 1'b1, 1'b1, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 4'd0);
        @(negedge PCLK);
        checkOutput("t5c.irq", 32'(TIMEOUT_IRQ), 32'd1);
`ifdef APB_DEC_ERR_LOG_EN
        checkOutput("t5c.err_cnt", 32'(ERR_CNT), 32'd1);
        checkOutput("t5c.err_type", 32'(ERR_TYPE), 32'd2);
        checkOutput("t5c.err_addr", 32'(ERR_ADDR), 32'd1);
`endif
        nextCycle();
        TIMEOUT_CLR = 1'b1;
        nextCycle();
        TIMEOUT_CLR = 1'b0;
        @(negedge PCLK);
        checkOutput("t5c.cleared.irq", 32'(TIMEOUT_IRQ), 32'd0);
`ifdef APB_DEC_ERR_LOG_EN
        checkOutput("t5c.cleared.err_cnt", 32'(ERR_CNT), 32'd0);
`endif
        nextCycle();
        PREADY_S[1] = 1'b1;

`ifdef APB_DEC_ERR_LOG_EN
        $display("[TB] error log: two unmapped at slot 9, one timeout on slot 5");
        for (int i = 0; i < 2; i++) begin
            setupCycle(4'd9);
            applyStimulus(1'b1, 1'b1, 4'd9);
            nextCycle();
        end
        applyStimulus(1'b0, 1'b0, 4'd0);
        @(negedge PCLK);
        checkOutput("t6.unmap.err_cnt", 32'(ERR_CNT), 32'd2);
        checkOutput("t6.unmap.err_type", 32'(ERR_TYPE), 32'd1);
        checkOutput("t6.unmap.err_addr", 32'(ERR_ADDR), 32'd9);
        nextCycle();
        PREADY_S[5] = 1'b0;
        setupCycle(4'd5);
        stallCycles(TMO, 4'd5, "t6");
        applyStimulus(1'b1, 1'b1, 4'd5);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 4'd0);
        @(negedge PCLK);
        checkOutput("t6.tmo.err_cnt", 32'(ERR_CNT), 32'd3);
        checkOutput("t6.tmo.err_type", 32'(ERR_TYPE), 32'd2);
        checkOutput("t6.tmo.err_addr", 32'(ERR_ADDR), 32'd5);
        nextCycle();
        PREADY_S[5] = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
